pkt_buffer_writer_v0_1: RTL and testbench
=========================================

# pkt_buffer_writer_v0_1

Write-side admission stage of the root PIFO packet buffer. It accepts packets on a slave AXI-Stream, allocates one buffer word per beat from the address manager's free-list head, and writes each beat into the packet data RAM. It drops whole packets when the address manager reports almost-full, and emits one descriptor (start address, word count) per stored packet toward the PIFO enqueue logic.

## Interface
- DATA_WIDTH, 256, data RAM word and tdata width
- ADDR_WIDTH, 12, buffer address width; must equal the address manager's ADDR_WIDTH
- LEN_WIDTH, 6, descriptor word-count width; counts saturate at 2^LEN_WIDTH-1
- CNT_WIDTH, 32, statistics counter width
- clk  in  1  system clock; all logic is rising-edge
- rstn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  DATA_WIDTH  packet beat
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat of packet
- s_axis_tready  out  1  beat accepted when tvalid&tready
- am_fl_head  in  ADDR_WIDTH  current free-list head from the address manager
- am_almost_full  in  1  address manager almost-full flag
- am_wr_en  out  1  one-cycle pulse per stored word; advances the free-list head
- am_first_word_en  out  1  tied 0; the read side drives the address manager's first-word input
- m_buf_wr_en  out  1  data RAM write enable
- m_buf_wr_addr  out  ADDR_WIDTH  data RAM write address
- m_buf_wr_data  out  DATA_WIDTH  data RAM write data
- m_desc_valid  out  1  descriptor valid
- m_desc_ready  in  1  descriptor accepted when valid&ready
- m_desc_sop_addr  out  ADDR_WIDTH  address of the packet's first word
- m_desc_len  out  LEN_WIDTH  number of words stored
- m_pkt_cnt  out  CNT_WIDTH  packets stored
- m_drop_cnt  out  CNT_WIDTH  packets dropped

## Operation
- The state machine has three states: IDLE, WRITE and DROP.
- "Accept" means s_axis_tvalid & s_axis_tready.
- s_axis_tready is ~m_desc_valid in IDLE and 1 in WRITE and DROP.
- Admission is decided only on the first beat, in IDLE.
  - If am_almost_full=1 on an accepted beat, the packet is dropped.
    - No RAM or address-manager write is made.
    - If tlast=1: m_drop_cnt increments and the state stays IDLE.
    - If tlast=0: the state moves to DROP.
  - Otherwise the beat is stored: m_buf_wr_en=am_wr_en=1, m_buf_wr_addr=am_fl_head, m_buf_wr_data=tdata.
    - sop_reg is loaded with am_fl_head and len_reg is loaded with 1.
    - If tlast=1, the descriptor is loaded and the state stays IDLE; otherwise the state moves to WRITE.
- WRITE:
  - Each accepted beat is stored at the current am_fl_head and len_reg increments (saturating).
  - am_almost_full is ignored mid-packet. Packets must be no longer than the address manager's almost-full threshold; the write-side source enforces this.
  - On an accepted tlast beat: the descriptor is loaded, m_pkt_cnt increments, and the state moves to IDLE.
- DROP:
  - Beats are consumed without any write.
  - On an accepted tlast beat: m_drop_cnt increments and the state moves to IDLE.
- Descriptor load:
  - m_desc_sop_addr = sop_reg, or am_fl_head for a single-beat packet.
  - m_desc_len = final length.
  - m_desc_valid is set and holds, with stable fields, until m_desc_ready=1.
- A packet stored directly from IDLE as a single beat also increments m_pkt_cnt.
- Counters wrap modulo 2^CNT_WIDTH.
- Write outputs (m_buf_wr_*, am_wr_en) are combinational from the accepted beat and am_fl_head. They are 0 whenever no store occurs.

## Timing
- Reset (rstn=0, asynchronous):
  - State returns to IDLE.
  - m_desc_valid=0, m_desc_sop_addr=0, m_desc_len=0.
  - m_pkt_cnt=0, m_drop_cnt=0.
  - s_axis_tready=1 (IDLE with no descriptor pending).
  - Write strobes are 0.
- Reset mid-packet abandons the packet silently. The address manager is reset by the same rstn.
- Store latency: the RAM write occurs in the same cycle the beat is accepted.
- The address manager advances am_fl_head by the next cycle, so back-to-back beats write consecutive free-list entries at one word per cycle.
- Descriptor latency: m_desc_valid rises the cycle after the tlast beat is accepted.
- m_desc_valid falls the cycle after valid&ready.
- While m_desc_valid=1 in IDLE, tready=0, so a new packet stalls until the descriptor is taken. Descriptor and data are never lost.
- am_almost_full is sampled only on the first-beat acceptance cycle. A change mid-packet has no effect.
- tvalid gaps inside a packet are legal. The state is held and no write occurs.

## Test plan
- Reset then a 3-beat packet with am_fl_head sequencing 0,1,2:
  - Three am_wr_en pulses at addresses 0,1,2.
  - Descriptor {sop=0, len=1+2=3} is valid one cycle after tlast.
  - m_pkt_cnt=1.
- Single-beat packet at am_fl_head=5 → one write at 5; descriptor {5,1}.
- am_almost_full=1 at the first beat of a 4-beat packet:
  - All 4 beats are accepted with zero writes.
  - m_drop_cnt=1, and no descriptor is produced.
- Back-to-back packets with m_desc_ready held 0:
  - The second packet's first beat sees tready=0 until ready pulses.
  - The first descriptor stays stable throughout.
- am_almost_full rising mid-packet → the packet is fully stored and the descriptor len equals the beat count.
- rstn asserted during WRITE → next cycle: IDLE, counters 0, m_desc_valid=0. A subsequent packet stores normally.

Source files
------------

// File: rtl/pkt_buffer_writer_v0_1.sv
// Write-side admission stage of the root PIFO packet buffer.
// Takes packets from a slave AXI-Stream, writes one buffer word per beat at the
// address manager's free-list head, drops whole packets that start while the
// address manager is almost full, and emits one {sop address, word count}
// descriptor per stored packet.
//
// Handshakes: every channel is strict valid/ready. A beat or descriptor
// transfers on the rising edge where valid and ready are both 1; a source
// holds valid and its payload stable until that edge, and ready never
// depends combinationally on valid.
module pkt_buffer_writer_v0_1 #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 6,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    // Packet input
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    // Address manager
    input  logic [ADDR_WIDTH-1:0] am_fl_head,
    input  logic                  am_almost_full,
    output logic                  am_wr_en,
    output logic                  am_first_word_en,
    // Data RAM write port
    output logic                  m_buf_wr_en,
    output logic [ADDR_WIDTH-1:0] m_buf_wr_addr,
    output logic [DATA_WIDTH-1:0] m_buf_wr_data,
    // Descriptor output
    output logic                  m_desc_valid,
    input  logic                  m_desc_ready,
    output logic [ADDR_WIDTH-1:0] m_desc_sop_addr,
    output logic [LEN_WIDTH-1:0]  m_desc_len,
    // Statistics
    output logic [CNT_WIDTH-1:0]  m_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  m_drop_cnt,
    // Debug view of the admission state machine
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sop_q, sop_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  desc_valid_q, desc_valid_d;
    logic [ADDR_WIDTH-1:0] desc_sop_q, desc_sop_d;
    logic [LEN_WIDTH-1:0]  desc_len_q, desc_len_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

    logic                  tready;
    logic                  accept;
    logic                  store;
    logic [LEN_WIDTH-1:0]  len_inc;

    // Handshake qualifiers and the saturating length increment
    always_comb begin
        tready  = (state_q == ST_IDLE) ? ~desc_valid_q : 1'b1;
        accept  = s_axis_tvalid & tready;
        len_inc = (&len_q) ? len_q : len_q + LEN_ONE;
    end

    // Next-state, store strobe, descriptor and counter updates
    always_comb begin
        state_d      = state_q;
        sop_d        = sop_q;
        len_d        = len_q;
        desc_valid_d = desc_valid_q;
        desc_sop_d   = desc_sop_q;
        desc_len_d   = desc_len_q;
        pkt_cnt_d    = pkt_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        store        = 1'b0;

        // Consumer took the pending descriptor; a load below can never
        // coincide with this because no packet starts while one is pending.
        if (desc_valid_q && m_desc_ready) begin
            desc_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (am_almost_full) begin
                        // Whole packet is discarded; nothing is written.
                        if (s_axis_tlast) begin
                            drop_cnt_d = drop_cnt_q + CNT_ONE;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end else begin
                        store = 1'b1;
                        sop_d = am_fl_head;
                        len_d = LEN_ONE;
                        if (s_axis_tlast) begin
                            // Single-beat packet: sop_q is not yet loaded,
                            // so the descriptor takes the head directly.
                            desc_valid_d = 1'b1;
                            desc_sop_d   = am_fl_head;
                            desc_len_d   = LEN_ONE;
                            pkt_cnt_d    = pkt_cnt_q + CNT_ONE;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end
                end
            end
            ST_WRITE: begin
                // Almost-full is deliberately ignored once a packet is admitted.
                if (accept) begin
                    store = 1'b1;
                    len_d = len_inc;
                    if (s_axis_tlast) begin
                        desc_valid_d = 1'b1;
                        desc_sop_d   = sop_q;
                        desc_len_d   = len_inc;
                        pkt_cnt_d    = pkt_cnt_q + CNT_ONE;
                        state_d      = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (accept && s_axis_tlast) begin
                    drop_cnt_d = drop_cnt_q + CNT_ONE;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            sop_q        <= '0;
            len_q        <= '0;
            desc_valid_q <= 1'b0;
            desc_sop_q   <= '0;
            desc_len_q   <= '0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sop_q        <= sop_d;
            len_q        <= len_d;
            desc_valid_q <= desc_valid_d;
            desc_sop_q   <= desc_sop_d;
            desc_len_q   <= desc_len_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Write port is combinational from the accepted beat; zero when idle.
    assign s_axis_tready    = tready;
    assign m_buf_wr_en      = store;
    assign am_wr_en         = store;
    assign am_first_word_en = 1'b0;
    assign m_buf_wr_addr    = store ? am_fl_head : '0;
    assign m_buf_wr_data    = store ? s_axis_tdata : '0;

    assign m_desc_valid     = desc_valid_q;
    assign m_desc_sop_addr  = desc_sop_q;
    assign m_desc_len       = desc_len_q;
    assign m_pkt_cnt        = pkt_cnt_q;
    assign m_drop_cnt       = drop_cnt_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_pkt_buffer_writer_v0_1.sv
// Bench for pkt_buffer_writer_v0_1: random packets against a packet-level
// reference model, plus the directed scenarios (single beat, drop, stalled
// descriptor, mid-packet almost-full, length saturation, mid-packet reset).
module tb_pkt_buffer_writer_v0_1;

    localparam int DW = 256;
    localparam int AW = 12;
    localparam int LW = 6;
    localparam int CW = 32;
    localparam int LEN_MAX = (1 << LW) - 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rstn;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT ----------------
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [AW-1:0] am_fl_head;
    logic          am_almost_full;
    logic          am_wr_en;
    logic          am_first_word_en;
    logic          m_buf_wr_en;
    logic [AW-1:0] m_buf_wr_addr;
    logic [DW-1:0] m_buf_wr_data;
    logic          m_desc_valid;
    logic          m_desc_ready;
    logic [AW-1:0] m_desc_sop_addr;
    logic [LW-1:0] m_desc_len;
    logic [CW-1:0] m_pkt_cnt;
    logic [CW-1:0] m_drop_cnt;
    logic [1:0]    dbg_state;

    pkt_buffer_writer_v0_1 #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tready    (s_axis_tready),
        .am_fl_head       (am_fl_head),
        .am_almost_full   (am_almost_full),
        .am_wr_en         (am_wr_en),
        .am_first_word_en (am_first_word_en),
        .m_buf_wr_en      (m_buf_wr_en),
        .m_buf_wr_addr    (m_buf_wr_addr),
        .m_buf_wr_data    (m_buf_wr_data),
        .m_desc_valid     (m_desc_valid),
        .m_desc_ready     (m_desc_ready),
        .m_desc_sop_addr  (m_desc_sop_addr),
        .m_desc_len       (m_desc_len),
        .m_pkt_cnt        (m_pkt_cnt),
        .m_drop_cnt       (m_drop_cnt),
        .dbg_state        (dbg_state)
    );

    // ---------------- address manager stand-in ----------------
    logic          head_load;
    logic [AW-1:0] head_load_val;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) am_fl_head <= '0;
        else if (head_load) am_fl_head <= head_load_val;
        else if (am_wr_en) am_fl_head <= am_fl_head + 1'b1;
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [AW+LW-1:0] exp_q[$];   // pending descriptors {sop, len}
    bit               m_in_pkt;
    bit               m_pkt_drop;
    bit               m_desc_pend;
    logic [AW-1:0]    m_sop;
    int               m_len;
    logic [CW-1:0]    m_pkt;
    logic [CW-1:0]    m_drop;

    always @(negedge clk) begin
        bit acc;
        bit st;
        bit exp_tready;
        if (!rstn) begin
            m_in_pkt    = 0;
            m_pkt_drop  = 0;
            m_desc_pend = 0;
            m_len       = 0;
            m_pkt       = '0;
            m_drop      = '0;
            exp_q.delete();
            check("rst_tready", s_axis_tready, 1'b1);
            check("rst_desc_valid", m_desc_valid, 1'b0);
            check("rst_desc_sop", m_desc_sop_addr, '0);
            check("rst_desc_len", m_desc_len, '0);
            check("rst_pkt_cnt", m_pkt_cnt, '0);
            check("rst_drop_cnt", m_drop_cnt, '0);
            check("rst_wr_strobes", {am_wr_en, m_buf_wr_en}, 2'b00);
        end else begin
            exp_tready = m_in_pkt || !m_desc_pend;
            check("tready", s_axis_tready, exp_tready);
            acc = s_axis_tvalid && exp_tready;
            st  = acc && (m_in_pkt ? !m_pkt_drop : !am_almost_full);
            check("buf_wr_en", m_buf_wr_en, st);
            check("am_wr_en", am_wr_en, st);
            check("am_first_word_en", am_first_word_en, 1'b0);
            if (st) begin
                check("wr_addr", m_buf_wr_addr, am_fl_head);
                check("wr_data", m_buf_wr_data, s_axis_tdata);
            end else begin
                check("wr_idle_addr_data", {m_buf_wr_addr, m_buf_wr_data}, '0);
            end
            check("desc_valid", m_desc_valid, m_desc_pend);
            if (m_desc_pend) begin
                if (exp_q.size() == 0) check("desc_queue_empty", 1'b1, 1'b0);
                else check("desc_fields", {m_desc_sop_addr, m_desc_len}, exp_q[0]);
            end
            check("pkt_cnt", m_pkt_cnt, m_pkt);
            check("drop_cnt", m_drop_cnt, m_drop);

            // advance model across the coming rising edge
            if (m_desc_pend && m_desc_ready) begin
                m_desc_pend = 0;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (acc) begin
                if (!m_in_pkt) begin
                    m_pkt_drop = am_almost_full;
                    m_sop      = am_fl_head;
                    m_len      = 1;
                end else if (m_len < LEN_MAX) begin
                    m_len++;
                end
                m_in_pkt = 1;
                if (s_axis_tlast) begin
                    m_in_pkt = 0;
                    if (m_pkt_drop) begin
                        m_drop = m_drop + 1;
                    end else begin
                        m_pkt       = m_pkt + 1;
                        m_desc_pend = 1;
                        exp_q.push_back({m_sop, m_len[LW-1:0]});
                    end
                end
            end
        end
    end

    // ---------------- descriptor consumer ----------------
    bit hold_ready = 0;

    initial begin
        m_desc_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_desc_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic wait_accept();
        int budget = 0;
        @(negedge clk);
        while (!s_axis_tready) begin
            budget++;
            if (budget > 500) begin
                check("accept_timeout", 1'b0, 1'b1);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int n, input bit af_first, input bit af_mid, input bit no_last);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid  = 1'b0;
                am_almost_full = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            s_axis_tvalid = 1'b1;
            for (int j = 0; j < DW / 32; j++) s_axis_tdata[j*32 +: 32] = $urandom;
            s_axis_tlast   = !no_last && (i == n - 1);
            am_almost_full = (i == 0) ? af_first : (af_mid ? 1'b1 : 1'($urandom_range(0, 1)));
            wait_accept();
        end
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        am_almost_full = 1'b0;
    endtask

    task automatic apply_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        rstn          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic load_head(input logic [AW-1:0] val);
        head_load     = 1'b1;
        head_load_val = val;
        @(posedge clk);
        #1;
        head_load = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        s_axis_tdata   = '0;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        am_almost_full = 1'b0;
        head_load      = 1'b0;
        head_load_val  = '0;
        rstn           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // 3-beat packet from head 0
        send_pkt(3, 1'b0, 1'b0, 1'b0);
        idle_cycles(6);

        // single-beat packet at head 5
        load_head(12'd5);
        send_pkt(1, 1'b0, 1'b0, 1'b0);
        idle_cycles(6);

        // 4-beat packet dropped at admission
        send_pkt(4, 1'b1, 1'b0, 1'b0);
        idle_cycles(3);

        // back-to-back packets with the descriptor held back
        hold_ready = 1;
        send_pkt(2, 1'b0, 1'b0, 1'b0);
        fork
            send_pkt(3, 1'b0, 1'b0, 1'b0);
            begin
                idle_cycles(12);
                hold_ready = 0;
            end
        join
        idle_cycles(6);

        // almost-full raised mid-packet
        send_pkt(5, 1'b0, 1'b1, 1'b0);
        idle_cycles(6);

        // long packet saturates the length field
        send_pkt(LEN_MAX + 7, 1'b0, 1'b0, 1'b0);
        idle_cycles(6);

        // random traffic
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(1, 6), ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(6);

        // reset in the middle of a stored packet, then a normal packet
        send_pkt(3, 1'b0, 1'b0, 1'b1);
        apply_reset();
        send_pkt(3, 1'b0, 1'b0, 1'b0);
        idle_cycles(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
